bram_port_arbiter: RTL

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter_pkg.sv | 33 +++
 rtl/bram_port_arbiter_if.sv | 41 ++++
 rtl/bram_port_arbiter_burst_fsm.sv | 108 ++++++++++
 rtl/bram_port_arbiter.sv | 82 ++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared widths, FSM encoding and helpers for the two-requester BRAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bram_port_arbiter_pkg;

    // Word address and data widths of the external single-port 2^18 x 8 BRAM.
    localparam int ADDR_WIDTH = 18;
    localparam int BIT_WIDTH  = 8;

    // Burst counter width; BURST_LEN is limited to 1..15 so it fits.
    localparam int CNT_WIDTH  = 4;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [BIT_WIDTH-1:0]  data_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;

    // Arbiter ownership states; encodings are fixed so that external
    // debug tooling can decode the state register directly.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Increment that sticks at 'limit' instead of wrapping.
    function automatic cnt_t cnt_sat_inc(input cnt_t cnt, input cnt_t limit);
        if (cnt >= limit) begin
            return limit;
        end
        return cnt + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bundle for both ports of the BRAM arbiter (req/we/addr/wdata in, gnt/rvalid/rdata out).
// Latency: gnt combinational with req; rvalid/rdata one cycle after an accepted read.
// Backpressure: requester holds req/we/addr/wdata stable until its gnt is seen high.
interface bram_port_arbiter_if;
    import bram_port_arbiter_pkg::*;

    // Requester 0
    logic  req0;
    logic  we0;
    addr_t addr0;
    data_t wdata0;
    logic  gnt0;
    logic  rvalid0;
    data_t rdata0;

    // Requester 1
    logic  req1;
    logic  we1;
    addr_t addr1;
    data_t wdata1;
    logic  gnt1;
    logic  rvalid1;
    data_t rdata1;

    // Requesters drive the access, observe grant and read return.
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1
    );

    // Arbiter side.
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1
    );

endinterface

// File: rtl/bram_port_arbiter_burst_fsm.sv
// Burst-limited round-robin grant FSM for two requesters (state, burst count, last owner, grant decode).
// Latency: grants are combinational from req and registered state; state updates on the next clk edge.
// Backpressure: a waiting requester is held off for at most BURST_LEN grants to the other one.
//
// Ports: clk, rst (sync, active-high); req0/req1 in; gnt0/gnt1 out (combinational, forced low in reset).
module arb_burst_fsm
    import bram_port_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam cnt_t BURST_MAX = CNT_WIDTH'(BURST_LEN);

    arb_state_t state, state_d;
    cnt_t       cnt, cnt_d;
    logic       last, last_d;   // owner of the most recently finished tenure
    logic       g0, g1;

    // Grant decode and next-state computation. The owner keeps the port
    // until its burst budget is spent while the other side waits, or until
    // it stops requesting; either way 'last' records who gave it up.
    always_comb begin
        g0      = 1'b0;
        g1      = 1'b0;
        state_d = state;
        cnt_d   = cnt;
        last_d  = last;

        case (state)
            IDLE: begin
                // Tie goes to whoever did not own the port last.
                if (req0 && (!req1 || last)) begin
                    g0      = 1'b1;
                    state_d = OWN0;
                    cnt_d   = CNT_WIDTH'(1);
                end else if (req1) begin
                    g1      = 1'b1;
                    state_d = OWN1;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end

            OWN0: begin
                if (req0 && ((cnt < BURST_MAX) || !req1)) begin
                    g0    = 1'b1;
                    cnt_d = cnt_sat_inc(cnt, BURST_MAX);
                end else begin
                    last_d = 1'b0;
                    if (req1) begin
                        g1      = 1'b1;
                        state_d = OWN1;
                        cnt_d   = CNT_WIDTH'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end

            OWN1: begin
                if (req1 && ((cnt < BURST_MAX) || !req0)) begin
                    g1    = 1'b1;
                    cnt_d = cnt_sat_inc(cnt, BURST_MAX);
                end else begin
                    last_d = 1'b1;
                    if (req0) begin
                        g0      = 1'b1;
                        state_d = OWN0;
                        cnt_d   = CNT_WIDTH'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset is synchronous, so the grant must be masked explicitly while
    // rst is high or a transfer could slip through in that cycle.
    assign gnt0 = g0 & ~rst;
    assign gnt1 = g1 & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;      // makes requester 0 win the first tie
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            last  <= last_d;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for one external single-port BRAM: burst-limited grants, BRAM mux, read return.
// Latency: access issued to BRAM in the grant cycle; read data returned with rvalid one cycle later.
// Backpressure: gnt low holds the requester; no buffering, the requester keeps its request stable.
//
// Ports: clk, rst (sync, active-high); rq (requester bundle, slave side);
//        bram_ena/bram_wea/bram_addra/bram_dina out to the BRAM, bram_douta in (1-cycle registered read).
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_port_arbiter_if.slave   rq,
    output logic                 bram_ena,
    output logic                 bram_wea,
    output addr_t                bram_addra,
    output data_t                bram_dina,
    input  data_t                bram_douta
);

    logic gnt0, gnt1;
    logic rvalid0_q, rvalid1_q;
    logic rvalid0, rvalid1;

    arb_burst_fsm #(
        .BURST_LEN (BURST_LEN)
    ) u_fsm (
        .clk  (clk),
        .rst  (rst),
        .req0 (rq.req0),
        .req1 (rq.req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign rq.gnt0 = gnt0;
    assign rq.gnt1 = gnt1;

    // BRAM port mux: the granted requester drives the port in the same
    // cycle; with no grant every BRAM input is parked at zero.
    always_comb begin
        bram_ena   = 1'b0;
        bram_wea   = 1'b0;
        bram_addra = '0;
        bram_dina  = '0;
        if (gnt0) begin
            bram_ena   = 1'b1;
            bram_wea   = rq.we0;
            bram_addra = rq.addr0;
            bram_dina  = rq.wdata0;
        end else if (gnt1) begin
            bram_ena   = 1'b1;
            bram_wea   = rq.we1;
            bram_addra = rq.addr1;
            bram_dina  = rq.wdata1;
        end
    end

    // Read-return tags line up with the BRAM's one-cycle output register,
    // so back-to-back reads come back back-to-back in grant order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 & ~rq.we0;
            rvalid1_q <= gnt1 & ~rq.we1;
        end
    end

    // A read accepted just before reset would otherwise return during the
    // first reset cycle; reset wins.
    assign rvalid0 = rvalid0_q & ~rst;
    assign rvalid1 = rvalid1_q & ~rst;

    assign rq.rvalid0 = rvalid0;
    assign rq.rvalid1 = rvalid1;
    assign rq.rdata0  = rvalid0 ? bram_douta : '0;
    assign rq.rdata1  = rvalid1 ? bram_douta : '0;

endmodule
